main_control_fsm: RTL
=====================

Name: main_control_fsm

Overview:
- Multicycle main control unit. Sequences each instruction through fetch, decode, execute, memory and writeback phases.
- Drives the 2-bit alu_op code consumed by the ALU-control decoder: 0 = ADD for address/PC math, 1 = SUB for branch compare, 2 = select by opcode.
- Drives all datapath enables. Stalls on a memory ready handshake, with a wait-timeout.
- Sits between the instruction register opcode field and the datapath/ALU-control.

Parameters:
OPW, 5, opcode width
MAX_WAIT, 15, max cycles spent waiting for mem_ready in one memory state before timeout (1..255)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
opcode  in  OPW  opcode field from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
alu_op  out  2  ALU operation class to ALU control
alu_src_a  out  1  0 = PC, 1 = register A
alu_src_b  out  2  0 = reg B, 1 = constant 1, 2 = sign-extended immediate
ir_write  out  1  load instruction register
pc_write  out  1  unconditional PC load
pc_src  out  2  0 = ALU result, 1 = ALUOut (branch target), 2 = register A (JR)
mem_read  out  1  memory read request
mem_write  out  1  memory write request
i_or_d  out  1  0 = PC address, 1 = ALUOut address
reg_write  out  1  register file write
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
illegal  out  1  one-cycle pulse on undefined opcode
timeout  out  1  one-cycle pulse on memory wait timeout
state  out  4  current state, for debug

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = RST(0); wait counter = 0; latched opcode = 0.
  - All outputs 0.
  - RST always goes to FETCH on the next edge.
- Outputs are Moore: decoded from the state register and the opcode latched in DECODE. illegal and timeout are registered pulses.
- Opcode map:
  - R-class: AND=00000, CAS=00001, ADD=00011, SUB=00100, CMP=00101.
  - LWS=00010, JR=00110.
  - I-class: ANDI=00111, ADDI=01000, LUI=01110.
  - LW=01001, SW=01011, BEQ=01010.
  - Any other value is undefined.
- States and outputs:
  - FETCH(1): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0.
    - ir_write and pc_write assert only in the cycle mem_ready=1; the state stays in FETCH until then.
  - DECODE(2): alu_src_a=0, alu_src_b=2, alu_op=0 (branch target into ALUOut). Latch opcode. Dispatch by class:
    - R-class -> EXEC_R.
    - I-class -> EXEC_I.
    - LW, SW -> ADDR (alu_src_b=2, alu_op=0).
    - LWS -> ADDR_R (alu_src_b=0, alu_op=2).
    - BEQ -> BRANCH.
    - JR -> JUMP.
    - Undefined -> FETCH, with illegal pulsed for 1 cycle.
  - EXEC_R(3): alu_src_a=1, alu_src_b=0, alu_op=2 -> WB_R(4).
  - WB_R(4): reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
  - EXEC_I(5): alu_src_a=1, alu_src_b=2, alu_op=2 -> WB_I(6).
  - WB_I(6): reg_write=1, reg_dst=0 -> FETCH.
  - ADDR(7) / ADDR_R(8): alu_src_a=1 -> MEM_RD(9) if LW/LWS, MEM_WR(10) if SW.
  - MEM_RD(9): mem_read=1, i_or_d=1. Hold until mem_ready=1 -> WB_MEM(11).
  - MEM_WR(10): mem_write=1, i_or_d=1. Hold until mem_ready=1 -> FETCH.
  - WB_MEM(11): reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
  - BRANCH(12): alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1; pc_write = zero (same cycle) -> FETCH.
  - JUMP(13): pc_src=2, pc_write=1 -> FETCH.
- Latency in cycles, zero wait states: R/I = 4, LW/LWS = 5, SW = 4, BEQ = 3, JR = 3. Each wait cycle adds 1.
- Wait counter (8-bit):
  - Counts cycles spent in FETCH/MEM_RD/MEM_WR with mem_ready=0; cleared on state change.
  - When it reaches MAX_WAIT with mem_ready still 0: pulse timeout, go to FETCH.
    - No ir_write, pc_write or reg_write on a timeout.
    - A timeout in FETCH restarts the fetch at the same PC.
  - mem_ready=1 in the same cycle the count reaches MAX_WAIT: the access completes, no timeout.
- Opcode changes after DECODE are ignored (the latched copy is used).
- rst_n asserted mid-instruction aborts immediately. No write enable may be high while rst_n is low.
- Unused state encodings (14, 15) -> FETCH.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0, state=0. Release -> state 0, 1, then FETCH outputs with mem_read=1.
- ADD (00011), mem_ready tied 1 -> states 1, 2, 3, 4, 1; alu_op=2 in EXEC_R; reg_write=1 and reg_dst=1 only in WB_R.
- LW (01001), mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles; WB_MEM has mem_to_reg=1, reg_write=1; total 8 cycles.
- BEQ (01010) with zero=1, then zero=0 -> alu_op=1 in BRANCH; pc_write=1 with pc_src=1 in the first case, pc_write=0 in the second.
- Opcode 11111 -> illegal pulses once after DECODE, returns to FETCH, no reg_write or mem_write.
- SW, mem_ready never asserted, MAX_WAIT=15 -> timeout pulses after 15 MEM_WR cycles, then FETCH; mem_ready arriving at exactly cycle 15 -> completes, no timeout.

Source files
------------

// File: rtl/main_control_fsm.sv
// Multicycle main control unit: steps each instruction through fetch, decode,
// execute, memory and writeback, with a bounded wait on the memory handshake.
module main_control_fsm #(
    parameter int OPW      = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic [1:0]     alu_op,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic           ir_write,
    output logic           pc_write,
    output logic [1:0]     pc_src,
    output logic           mem_read,
    output logic           mem_write,
    output logic           i_or_d,
    output logic           reg_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           illegal,
    output logic           timeout,
    output logic [3:0]     state
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_EXEC_I = 4'd5,
        S_WB_I   = 4'd6,
        S_ADDR   = 4'd7,
        S_ADDR_R = 4'd8,
        S_MEM_RD = 4'd9,
        S_MEM_WR = 4'd10,
        S_WB_MEM = 4'd11,
        S_BRANCH = 4'd12,
        S_JUMP   = 4'd13
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_I, C_LDST, C_LWS, C_BEQ, C_JR, C_BAD
    } op_class_t;

    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00000);
    localparam logic [OPW-1:0] OP_CAS  = OPW'(5'b00001);
    localparam logic [OPW-1:0] OP_LWS  = OPW'(5'b00010);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_CMP  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_JR   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b00111);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01000);
    localparam logic [OPW-1:0] OP_LW   = OPW'(5'b01001);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(5'b01010);
    localparam logic [OPW-1:0] OP_SW   = OPW'(5'b01011);
    localparam logic [OPW-1:0] OP_LUI  = OPW'(5'b01110);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    function automatic op_class_t classify(input logic [OPW-1:0] op);
        op_class_t c;
        case (op)
            OP_AND, OP_CAS, OP_ADD, OP_SUB, OP_CMP: c = C_R;
            OP_ANDI, OP_ADDI, OP_LUI:               c = C_I;
            OP_LW, OP_SW:                           c = C_LDST;
            OP_LWS:                                 c = C_LWS;
            OP_BEQ:                                 c = C_BEQ;
            OP_JR:                                  c = C_JR;
            default:                                c = C_BAD;
        endcase
        return c;
    endfunction

    state_t         state_reg;
    logic [7:0]     wait_cnt_reg;
    logic [OPW-1:0] opcode_reg;
    logic           illegal_reg;
    logic           timeout_reg;
    logic           wait_expired;

    // The last permitted wait cycle still completes if mem_ready arrives in it.
    assign wait_expired = !mem_ready && (wait_cnt_reg == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_RST;
            wait_cnt_reg <= 8'd0;
            opcode_reg   <= '0;
            illegal_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            illegal_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
            wait_cnt_reg <= 8'd0;
            case (state_reg)
                S_RST: state_reg <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) begin
                        state_reg <= S_DECODE;
                    end else if (wait_expired) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= S_FETCH;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                S_DECODE: begin
                    opcode_reg <= opcode;
                    case (classify(opcode))
                        C_R:    state_reg <= S_EXEC_R;
                        C_I:    state_reg <= S_EXEC_I;
                        C_LDST: state_reg <= S_ADDR;
                        C_LWS:  state_reg <= S_ADDR_R;
                        C_BEQ:  state_reg <= S_BRANCH;
                        C_JR:   state_reg <= S_JUMP;
                        default: begin
                            illegal_reg <= 1'b1;
                            state_reg   <= S_FETCH;
                        end
                    endcase
                end
                S_EXEC_R: state_reg <= S_WB_R;
                S_EXEC_I: state_reg <= S_WB_I;
                S_ADDR, S_ADDR_R:
                    state_reg <= (opcode_reg == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD: begin
                    if (mem_ready) begin
                        state_reg <= S_WB_MEM;
                    end else if (wait_expired) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= S_FETCH;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                S_MEM_WR: begin
                    if (mem_ready) begin
                        state_reg <= S_FETCH;
                    end else if (wait_expired) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= S_FETCH;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                default: state_reg <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        alu_op     = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'd2;
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = 2'd2;
            end
            S_WB_I: reg_write = 1'b1;
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_ADDR_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd1;
                pc_src    = 2'd1;
                pc_write  = zero;
            end
            S_JUMP: begin
                pc_src   = 2'd2;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal = illegal_reg;
    assign timeout = timeout_reg;
    assign state   = state_reg;

endmodule
